iris_frame_sequencer: RTL and testbench
=======================================

# iris_frame_sequencer

Sequential front/back end for the combinational Iris MLP classifier. It accepts raw feature samples as a valid/ready stream and quantizes each one to the classifier's 4-bit input format. It packs each completed four-feature frame into the 16-bit feature vector and holds it stable while the classifier output settles. It then captures the 2-bit class and returns it, with a frame tag, over a valid/ready result stream.

## Interface
Parameters:
- RAW_W, 8, raw feature width (unsigned).
- FEAT_W, 4, quantized feature width; fixed to 4 (classifier input format).
- N_FEAT, 4, features per frame; fixed to 4.
- SETTLE, 2, cycles `feat_vec` is held before `cls_in` is sampled; legal range 1..15.
- TAG_W, 8, frame tag width.

Ports:
- clk, input, 1, sole clock; all state changes on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- s_valid, input, 1, raw feature beat valid.
- s_ready, output, 1, block accepts a beat.
- s_data, input, RAW_W, raw unsigned feature value.
- s_last, input, 1, marks the final beat of a frame.
- feat_vec, output, 16, packed vector to classifier: [3:0]=feature0, [7:4]=feature1, [11:8]=feature2, [15:12]=feature3.
- cls_in, input, 2, class index returned by classifier.
- m_valid, output, 1, result valid.
- m_ready, input, 1, result consumer ready.
- m_class, output, 2, captured class.
- m_tag, output, TAG_W, sequence number of the frame the result belongs to.
- err_frame, output, 1, one-cycle pulse on malformed frame.

## Operation
- Quantization per beat: q = min(15, (raw + 2^(RAW_W-FEAT_W-1)) >> (RAW_W-FEAT_W)), i.e. round-half-up then saturate. Intermediate sum is RAW_W+1 bits wide, with no overflow.
- Beats are written into a 16-bit staging register at slot `beat_cnt` (0..3). `feat_vec` is a separate register loaded from staging, with the final beat merged in, only on commit. `feat_vec` therefore never shows a partial frame.
- States: COLLECT, DROP, SETTLE, OUTPUT.
- COLLECT: s_ready=1. On an accepted beat:
  - beat_cnt<3 and s_last=0: store the beat, beat_cnt++.
  - beat_cnt<3 and s_last=1 (short frame): pulse err_frame, discard the frame, beat_cnt=0, stay in COLLECT.
  - beat_cnt=3 and s_last=1: commit (feat_vec updated), load settle counter with SETTLE, go to SETTLE.
  - beat_cnt=3 and s_last=0 (long frame): pulse err_frame, discard, go to DROP.
- DROP: s_ready=1. Accepted beats are discarded. An accepted beat with s_last=1 returns to COLLECT with beat_cnt=0. No further err_frame pulses for the same frame.
- SETTLE: s_ready=0. The counter decrements each cycle. At the edge where it reaches 0, cls_in is sampled into m_class, m_tag is loaded from the tag counter, m_valid goes to 1, and the state goes to OUTPUT.
- OUTPUT: s_ready=0. m_valid, m_class and m_tag are held stable until m_ready=1. On the handshake edge: m_valid=0, tag counter increments (wraps 2^TAG_W-1 → 0), go to COLLECT.
- The tag counter counts successfully delivered results only. Malformed frames do not consume a tag.
- feat_vec keeps the last committed frame until the next commit.

## Timing
- Reset values while rst=1: state=COLLECT, beat_cnt=0, s_ready=0 (gated by rst), feat_vec=0, m_valid=0, m_class=0, m_tag=0, tag counter=0, err_frame=0, staging=0.
- s_ready rises combinationally from state once rst deasserts.
- Latency: final beat accepted at edge E0 → feat_vec valid after E0 → cls_in sampled at edge E0+SETTLE → m_valid high from E0+SETTLE. With SETTLE=2, m_valid is visible 2 cycles after the last beat's edge.
- err_frame is registered. It is high for exactly the cycle after the offending beat's edge.
- After a result handshake at edge Ek, s_ready=1 in the cycle after Ek. The minimum frame period is N_FEAT+SETTLE+1 cycles when m_ready is held at 1.
- m_valid is never dropped without a handshake. m_class and m_tag never change while m_valid=1 and m_ready=0.
- Reset asserted mid-frame, mid-SETTLE or mid-OUTPUT: all outputs go to their reset values immediately (asynchronous). The pending frame or result is lost and the tag restarts at 0.

## Test plan
- Quantization and packing: beats 0x00, 0x17, 0x18, 0xFF with s_last on the 4th → feat_vec=16'hF210. Classifier stub drives cls_in=2'b10 → m_valid after 2 edges, m_class=2, m_tag=0.
- Backpressure: hold m_ready=0 for 10 cycles during OUTPUT → m_valid, m_class and m_tag stable, s_ready=0. Release → one handshake, tag counter=1, s_ready=1 next cycle.
- Short frame: s_last on the 2nd beat → err_frame one-cycle pulse, feat_vec unchanged. The next well-formed frame is accepted with m_tag=0.
- Long frame: 6 beats with s_last on the 6th → err_frame pulses once after beat 4, beats 5-6 dropped, no result produced. The next frame completes normally.
- Tag wrap and throughput: 257 back-to-back frames with m_ready=1 → consecutive tags 0..255 then 0. Frame period is exactly 7 cycles with SETTLE=2.
- Async reset mid-SETTLE: assert rst between the commit edge and the capture edge → m_valid stays 0, feat_vec=0 immediately. After release, s_ready=1 and the next result has m_tag=0.

Source files
------------

// File: rtl/iris_frame_sequencer.sv
// Iris frame sequencer: quantizes a raw feature stream into 4-bit features,
// packs four of them into the classifier input vector, waits for the
// combinational classifier to settle, then returns the class with a frame tag.
module iris_frame_sequencer #(
    parameter int unsigned RAW_W  = 8,
    parameter int unsigned FEAT_W = 4,
    parameter int unsigned N_FEAT = 4,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [RAW_W-1:0] s_data,
    input  logic             s_last,
    output logic [15:0]      feat_vec,
    input  logic [1:0]       cls_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       m_class,
    output logic [TAG_W-1:0] m_tag,
    output logic             err_frame
);

    localparam int unsigned SHIFT = RAW_W - FEAT_W;
    localparam int unsigned CNT_W = $clog2(N_FEAT);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_FEAT - 1);
    localparam logic [RAW_W:0] ROUND = (RAW_W + 1)'(1) << (SHIFT - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

    typedef enum logic [1:0] {
        StCollect,
        StDrop,
        StSettle,
        StOutput
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [15:0]        staging_q, staging_d;
    logic [15:0]        feat_q, feat_d;
    logic [3:0]         settle_q, settle_d;
    logic               m_valid_q, m_valid_d;
    logic [1:0]         m_class_q, m_class_d;
    logic [TAG_W-1:0]   m_tag_q, m_tag_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               err_q, err_d;

    logic [RAW_W:0]     q_sum;
    logic [FEAT_W:0]    q_shift;
    logic [FEAT_W-1:0]  q_feat;
    logic               accept;

    // Round-half-up to FEAT_W bits, saturating at the all-ones code.
    always_comb begin
        q_sum   = {1'b0, s_data} + ROUND;
        q_shift = (FEAT_W + 1)'(q_sum >> SHIFT);
        q_feat  = q_shift[FEAT_W] ? {FEAT_W{1'b1}} : q_shift[FEAT_W-1:0];
    end

    // Input is only open while collecting or draining; held low during reset.
    always_comb begin
        s_ready = !rst && ((state_q == StCollect) || (state_q == StDrop));
        accept  = s_valid && s_ready;
    end

    // Next-state: frame assembly, settle countdown, result handshake.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        staging_d = staging_q;
        feat_d    = feat_q;
        settle_d  = settle_q;
        m_valid_d = m_valid_q;
        m_class_d = m_class_q;
        m_tag_d   = m_tag_q;
        tag_d     = tag_q;
        err_d     = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    if (beat_q != LAST_BEAT) begin
                        if (s_last) begin
                            // Short frame: drop what was gathered so far.
                            err_d  = 1'b1;
                            beat_d = '0;
                        end else begin
                            staging_d[int'(beat_q)*FEAT_W +: FEAT_W] = q_feat;
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        beat_d = '0;
                        if (s_last) begin
                            // Commit the whole frame at once so the classifier
                            // never sees a partially updated vector.
                            feat_d = staging_q;
                            feat_d[(N_FEAT-1)*FEAT_W +: FEAT_W] = q_feat;
                            settle_d = SETTLE_LOAD;
                            state_d  = StSettle;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrop;
                        end
                    end
                end
            end
            StDrop: begin
                if (accept && s_last) begin
                    state_d = StCollect;
                end
            end
            StSettle: begin
                if (settle_q <= 4'd1) begin
                    settle_d  = '0;
                    m_class_d = cls_in;
                    m_tag_d   = tag_q;
                    m_valid_d = 1'b1;
                    state_d   = StOutput;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StOutput: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    tag_d     = tag_q + 1'b1;
                    state_d   = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StCollect;
            beat_q    <= '0;
            staging_q <= '0;
            feat_q    <= '0;
            settle_q  <= '0;
            m_valid_q <= 1'b0;
            m_class_q <= '0;
            m_tag_q   <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            staging_q <= staging_d;
            feat_q    <= feat_d;
            settle_q  <= settle_d;
            m_valid_q <= m_valid_d;
            m_class_q <= m_class_d;
            m_tag_q   <= m_tag_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
        end
    end

    assign feat_vec  = feat_q;
    assign m_valid   = m_valid_q;
    assign m_class   = m_class_q;
    assign m_tag     = m_tag_q;
    assign err_frame = err_q;

endmodule

// File: tb/tb_iris_frame_sequencer.sv
// Directed bench for iris_frame_sequencer: table of frames plus hand-written
// sequences for backpressure, malformed frames, reset and tag wrap.
module tb_iris_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [15:0] feat_vec;
    logic [1:0]  cls_in;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  m_class;
    logic [7:0]  m_tag;
    logic        err_frame;

    int n_checks = 0;
    int n_fail   = 0;

    iris_frame_sequencer #(
        .RAW_W (8),
        .FEAT_W(4),
        .N_FEAT(4),
        .SETTLE(2),
        .TAG_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .feat_vec (feat_vec),
        .cls_in   (cls_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_class  (m_class),
        .m_tag    (m_tag),
        .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] beats;  // beat0 in [7:0]
        logic [1:0]  cls;
        logic [15:0] feat;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and return 1ns after the edge that accepted it.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!s_ready) check("beat_accept_wait", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input logic [7:0] tag, input int hold);
        cls_in = v.cls;
        for (int b = 0; b < 4; b++) send_beat(v.beats[b*8 +: 8], (b == 3));
        check("feat_vec", {16'd0, feat_vec}, {16'd0, v.feat});
        check("s_ready_settle", {31'd0, s_ready}, 32'd0);
        step();
        check("m_valid_early", {31'd0, m_valid}, 32'd0);
        step();
        check("m_valid", {31'd0, m_valid}, 32'd1);
        check("m_class", {30'd0, m_class}, {30'd0, v.cls});
        check("m_tag", {24'd0, m_tag}, {24'd0, tag});
        for (int h = 0; h < hold; h++) begin
            cls_in = ~cls_in;
            step();
            check("hold_m_valid", {31'd0, m_valid}, 32'd1);
            check("hold_m_class", {30'd0, m_class}, {30'd0, v.cls});
            check("hold_m_tag", {24'd0, m_tag}, {24'd0, tag});
            check("hold_s_ready", {31'd0, s_ready}, 32'd0);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("m_valid_after_hs", {31'd0, m_valid}, 32'd0);
        check("s_ready_after_hs", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bp;
        int   beat;
        int   n_res;
        int   cyc;
        int   last_hs;
        logic acc;

        // Expected packing: [3:0]=q(beat0) ... [15:12]=q(beat3).
        vecs[0] = '{beats: 32'hFF18_1700, cls: 2'd2, feat: 16'hF210};
        vecs[1] = '{beats: 32'hF8F7_0708, cls: 2'd1, feat: 16'hFF01};
        vecs[2] = '{beats: 32'hE827_4080, cls: 2'd3, feat: 16'hF248};
        vecs[3] = '{beats: 32'h4030_2010, cls: 2'd0, feat: 16'h4321};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        cls_in  = '0;
        m_ready = 1'b0;
        step();
        step();
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_feat_vec", {16'd0, feat_vec}, 32'd0);
        check("rst_m_tag", {24'd0, m_tag}, 32'd0);
        check("rst_m_class", {30'd0, m_class}, 32'd0);
        check("rst_err", {31'd0, err_frame}, 32'd0);
        rst = 1'b0;
        #1;
        check("s_ready_after_rst", {31'd0, s_ready}, 32'd1);

        // Short frame: s_last on the second beat.
        send_beat(8'h55, 1'b0);
        check("short_no_err_beat1", {31'd0, err_frame}, 32'd0);
        send_beat(8'h66, 1'b1);
        check("short_err", {31'd0, err_frame}, 32'd1);
        check("short_feat_vec", {16'd0, feat_vec}, 32'd0);
        step();
        check("short_err_clear", {31'd0, err_frame}, 32'd0);
        check("short_no_result", {31'd0, m_valid}, 32'd0);

        // Table of well-formed frames; the first also shows the tag was not consumed.
        for (int i = 0; i < 4; i++) run_frame(vecs[i], 8'(i), 0);

        // Backpressure for 10 cycles.
        bp = '{beats: 32'h0102_0304, cls: 2'd1, feat: 16'h0000};
        run_frame(bp, 8'd4, 10);

        // Long frame: six beats, s_last on the sixth.
        for (int b = 0; b < 3; b++) begin
            send_beat(8'hAA, 1'b0);
            check("long_no_err_early", {31'd0, err_frame}, 32'd0);
        end
        send_beat(8'hAA, 1'b0);
        check("long_err", {31'd0, err_frame}, 32'd1);
        send_beat(8'hBB, 1'b0);
        check("long_err_once_b5", {31'd0, err_frame}, 32'd0);
        send_beat(8'hCC, 1'b1);
        check("long_err_once_b6", {31'd0, err_frame}, 32'd0);
        check("long_feat_kept", {16'd0, feat_vec}, {16'd0, bp.feat});
        for (int c = 0; c < 4; c++) begin
            check("long_no_result", {31'd0, m_valid}, 32'd0);
            step();
        end
        check("long_s_ready", {31'd0, s_ready}, 32'd1);
        run_frame(vecs[2], 8'd5, 0);

        // Reset between commit and capture.
        cls_in = 2'd3;
        for (int b = 0; b < 4; b++) send_beat(vecs[0].beats[b*8 +: 8], (b == 3));
        check("pre_rst_feat", {16'd0, feat_vec}, 32'h0000_F210);
        rst = 1'b1;
        #1;
        check("midrst_feat_vec", {16'd0, feat_vec}, 32'd0);
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        step();
        step();
        check("midrst_m_valid_held", {31'd0, m_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        step();
        step();
        check("post_rst_no_result", {31'd0, m_valid}, 32'd0);
        run_frame(vecs[1], 8'd0, 0);

        // Back-to-back frames with m_ready held: tags wrap, period 7 cycles.
        pulse_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        beat    = 0;
        n_res   = 0;
        cyc     = 0;
        last_hs = 0;
        while (n_res < 257 && cyc < 257 * 7 + 50) begin
            s_data = 8'(cyc * 37);
            s_last = (beat == 3);
            acc    = s_ready;
            if (m_valid) begin
                check("wrap_tag", {24'd0, m_tag}, 32'(n_res % 256));
                if (n_res > 0) check("frame_period", 32'(cyc - last_hs), 32'd7);
                last_hs = cyc;
                n_res++;
            end
            step();
            cyc++;
            if (acc) beat = (beat == 3) ? 0 : beat + 1;
        end
        if (n_res < 257) check("wrap_result_count", 32'(n_res), 32'd257);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
